// File: rtl/sram_line_loader_pkg.sv
// Shared types and constants for the SRAM line loader: FSM state encoding,
// default write-cycle timing and the number of stream words per line.
package sram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    localparam int T_SETUP_D = 1;
    localparam int T_PULSE_D = 2;
    localparam int T_HOLD_D  = 1;

    localparam int WORDW_D = 32;
    localparam int LINEW_D = 128;
    localparam int LANES   = LINEW_D / WORDW_D;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_line_loader_if.sv
// Stream input plus the SRAM array pin bundle driven by the loader.
// master = loader side, slave = stream source / SRAM array side.
interface sram_line_loader_if #(
    parameter int ADDRW = 19,
    parameter int WORDW = 32,
    parameter int LINEW = 128
);
    logic             s_valid;
    logic             s_ready;
    logic [WORDW-1:0] s_data;

    logic [ADDRW-1:0] SRAM_ADDR_Stream;
    logic [LINEW-1:0] SRAM_DATA_IN_Stream;
    logic             SRAM_CS;
    logic             SRAM_WR;
    logic             mode_R1_W0;

    modport master (
        input  s_valid,
        input  s_data,
        output s_ready,
        output SRAM_ADDR_Stream,
        output SRAM_DATA_IN_Stream,
        output SRAM_CS,
        output SRAM_WR,
        output mode_R1_W0
    );

    modport slave (
        output s_valid,
        output s_data,
        input  s_ready,
        input  SRAM_ADDR_Stream,
        input  SRAM_DATA_IN_Stream,
        input  SRAM_CS,
        input  SRAM_WR,
        input  mode_R1_W0
    );
endinterface

// File: rtl/sram_line_loader_packer.sv
// Packs accepted stream words into lanes of one line and keeps a running
// XOR checksum; line_full flags acceptance of the last lane.
module line_packer
    import sram_loader_pkg::*;
#(
    parameter int WORDW = 32,
    parameter int LINEW = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fill_en,
    input  logic             s_valid,
    input  logic [WORDW-1:0] s_data,
    output logic [LINEW-1:0] line,
    output logic [WORDW-1:0] checksum,
    output logic             line_full
);
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [IDXW-1:0]  idx_reg;
    logic [WORDW-1:0] checksum_reg;
    logic [WORDW-1:0] lane_reg [LANES];
    logic             accept;

    assign accept    = fill_en && s_valid;
    assign line_full = accept && (idx_reg == IDXW'(LANES - 1));
    assign checksum  = checksum_reg;

    // Index wraps naturally back to lane 0 after the last lane.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_reg      <= '0;
            checksum_reg <= '0;
        end else if (accept) begin
            idx_reg      <= idx_reg + IDXW'(1);
            checksum_reg <= checksum_reg ^ s_data;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    lane_reg[gi] <= '0;
                end else if (accept && (idx_reg == IDXW'(gi))) begin
                    lane_reg[gi] <= s_data;
                end
            end
            assign line[gi*WORDW +: WORDW] = lane_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/sram_line_loader.sv
// Bulk SRAM initialiser: packs stream words into lines and writes them to
// consecutive line addresses with a timed setup/pulse/hold async write cycle.
module sram_line_loader
    import sram_loader_pkg::*;
#(
    parameter int ADDRW   = 19,
    parameter int WORDW   = WORDW_D,
    parameter int LINEW   = LINEW_D,
    parameter int T_SETUP = T_SETUP_D,
    parameter int T_PULSE = T_PULSE_D,
    parameter int T_HOLD  = T_HOLD_D
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [ADDRW-1:0]    base_addr,
    input  logic [ADDRW-1:0]    line_count,
    sram_line_loader_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic [WORDW-1:0]    checksum
);
    localparam int T_MAX = max3(T_SETUP, T_PULSE, T_HOLD);
    localparam int PW    = $clog2(T_MAX + 1);

    state_t           state_reg;
    logic [PW-1:0]    phase_reg;
    logic [ADDRW-1:0] addr_reg;
    logic [ADDRW-1:0] lines_left_reg;
    logic             s_ready_reg;
    logic             cs_reg;
    logic             wr_reg;
    logic             mode_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             start_ok;
    logic             line_full;
    logic [LINEW-1:0] line_data;

    assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE));

    line_packer #(
        .WORDW (WORDW),
        .LINEW (LINEW)
    ) u_packer (
        .clk       (CLK),
        .rst       (RST),
        .clear     (start_ok),
        .fill_en   (s_ready_reg),
        .s_valid   (bus.s_valid),
        .s_data    (bus.s_data),
        .line      (line_data),
        .checksum  (checksum),
        .line_full (line_full)
    );

    // Every pin-facing control is a register updated on the transition into
    // the state that needs it, so the SRAM sees glitch-free strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            phase_reg      <= '0;
            addr_reg       <= '0;
            lines_left_reg <= '0;
            s_ready_reg    <= 1'b0;
            cs_reg         <= 1'b1;
            wr_reg         <= 1'b1;
            mode_reg       <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        addr_reg       <= base_addr;
                        lines_left_reg <= line_count;
                        if (line_count == '0) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= FILL;
                            busy_reg    <= 1'b1;
                            done_reg    <= 1'b0;
                            mode_reg    <= 1'b0;
                            s_ready_reg <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (line_full) begin
                        state_reg   <= SETUP;
                        s_ready_reg <= 1'b0;
                        cs_reg      <= 1'b0;
                        phase_reg   <= PW'(T_SETUP - 1);
                    end
                end

                SETUP: begin
                    if (phase_reg == '0) begin
                        state_reg <= PULSE;
                        wr_reg    <= 1'b0;
                        phase_reg <= PW'(T_PULSE - 1);
                    end else begin
                        phase_reg <= phase_reg - PW'(1);
                    end
                end

                PULSE: begin
                    if (phase_reg == '0) begin
                        state_reg <= HOLD;
                        wr_reg    <= 1'b1;
                        phase_reg <= PW'(T_HOLD - 1);
                    end else begin
                        phase_reg <= phase_reg - PW'(1);
                    end
                end

                HOLD: begin
                    if (phase_reg == '0) begin
                        addr_reg       <= addr_reg + ADDRW'(1);
                        lines_left_reg <= lines_left_reg - ADDRW'(1);
                        cs_reg         <= 1'b1;
                        if (lines_left_reg == ADDRW'(1)) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            mode_reg  <= 1'b1;
                        end else begin
                            state_reg   <= FILL;
                            s_ready_reg <= 1'b1;
                        end
                    end else begin
                        phase_reg <= phase_reg - PW'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready             = s_ready_reg;
    assign bus.SRAM_ADDR_Stream    = addr_reg;
    assign bus.SRAM_DATA_IN_Stream = line_data;
    assign bus.SRAM_CS             = cs_reg;
    assign bus.SRAM_WR             = wr_reg;
    assign bus.mode_R1_W0          = mode_reg;
    assign busy                    = busy_reg;
    assign done                    = done_reg;

endmodule
